// File: rtl/seq_divider_4bit_pkg.sv
// rtl/seq_divider_4bit_pkg.sv - shared state encoding and sizing for the sequential divider
package seq_divider_4bit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 4;

  function automatic int cnt_width(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/seq_divider_4bit_div_step.sv
// rtl/seq_divider_4bit_div_step.sv - one combinational restoring shift-subtract step
module div_step
  import seq_divider_4bit_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH:0]   a_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] m_i,
  output logic [WIDTH:0]   a_o,
  output logic [WIDTH-1:0] q_o
);

  logic [2*WIDTH:0] shifted;
  logic [WIDTH:0]   a_sh;
  logic [WIDTH:0]   trial;

  assign shifted = {a_i, q_i} << 1;
  assign a_sh    = shifted[2*WIDTH:WIDTH];
  // A stays below M, so a negative trial always shows up in the extra top bit
  assign trial   = a_sh - {1'b0, m_i};

  always_comb begin
    a_o = a_sh;
    q_o = shifted[WIDTH-1:0];
    if (!trial[WIDTH]) begin
      a_o    = trial;
      q_o[0] = 1'b1;
    end
  end

endmodule

// File: rtl/seq_divider_4bit.sv
// rtl/seq_divider_4bit.sv - multi-cycle restoring divider with start/busy/done handshake
module seq_divider_4bit
  import seq_divider_4bit_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             DivByZero
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH:0]   a_q, a_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   step_a;
  logic [WIDTH-1:0] step_q;

  div_step #(.WIDTH(WIDTH)) u_step (
    .a_i (a_q),
    .q_i (q_q),
    .m_i (m_q),
    .a_o (step_a),
    .q_o (step_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      a_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      a_q     <= a_d;
      q_q     <= q_d;
      m_q     <= m_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    a_d     = a_q;
    q_d     = q_q;
    m_d     = m_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          a_d     = '0;
          q_d     = Dividend;
          m_d     = Divisor;
          count_d = '0;
          // A zero divisor bypasses the iterations and reports immediately
          if (Divisor == '0) begin
            state_d = DONE;
            quot_d  = '1;
            rem_d   = Dividend;
            dbz_d   = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        a_d     = step_a;
        q_d     = step_q;
        count_d = count_q + 1'b1;
        if (count_q == LAST) begin
          state_d = DONE;
          quot_d  = step_q;
          rem_d   = step_a[WIDTH-1:0];
          dbz_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign Quotient  = quot_q;
  assign Remainder = rem_q;
  assign DivByZero = dbz_q;

endmodule

// File: tb/tb_seq_divider_4bit.sv
// tb/tb_seq_divider_4bit.sv - self-checking bench for the sequential divider
module tb_seq_divider_4bit;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] Dividend;
  logic [W-1:0] Divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] Quotient;
  logic [W-1:0] Remainder;
  logic         DivByZero;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seq_divider_4bit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .Dividend  (Dividend),
    .Divisor   (Divisor),
    .busy      (busy),
    .done      (done),
    .Quotient  (Quotient),
    .Remainder (Remainder),
    .DivByZero (DivByZero)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errs = errs + 1;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: tracks phase and a cycle budget, results from / and %
  typedef enum int {M_IDLE, M_RUN, M_DONE} mphase_e;
  mphase_e      ph = M_IDLE;
  int           left = 0;
  logic [W-1:0] op_n, op_d, eq, er;
  logic         ez;
  bit           mval = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      ph   <= M_IDLE;
      left <= 0;
      eq   <= '0;
      er   <= '0;
      ez   <= 1'b0;
      mval <= 1'b1;
    end else if (ph != M_RUN && start) begin
      if (Divisor == '0) begin
        ph <= M_DONE;
        eq <= '1;
        er <= Dividend;
        ez <= 1'b1;
      end else begin
        ph   <= M_RUN;
        left <= W;
        op_n <= Dividend;
        op_d <= Divisor;
      end
    end else if (ph == M_RUN) begin
      left <= left - 1;
      if (left == 1) begin
        ph <= M_DONE;
        eq <= op_n / op_d;
        er <= op_n % op_d;
        ez <= 1'b0;
      end
    end else begin
      ph <= M_IDLE;
    end
  end

  always @(negedge clk) begin
    if (mval) begin
      chk("model_busy", 32'(busy), 32'(ph == M_RUN));
      chk("model_done", 32'(done), 32'(ph == M_DONE));
      chk("model_quotient", 32'(Quotient), 32'(eq));
      chk("model_remainder", 32'(Remainder), 32'(er));
      chk("model_divbyzero", 32'(DivByZero), 32'(ez));
    end
  end

  // lat counts rising edges from the accepting edge (1) to the one entering DONE
  task automatic run_op(input bit imm, input logic [W-1:0] n, input logic [W-1:0] d,
                        output int lat);
    if (!imm) @(negedge clk);
    Dividend = n;
    Divisor  = d;
    start    = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    start    = 1'b0;
    Dividend = ~n;
    Divisor  = d ^ 4'h5;
    while (!done && lat < 20) begin
      @(posedge clk);
      lat = lat + 1;
      @(negedge clk);
    end
    if (!done) chk("done_timeout", 32'(done), 32'd1);
  endtask

  int lat;

  initial begin
    rst = 1'b1;
    start = 1'b0;
    Dividend = '0;
    Divisor = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_quotient", 32'(Quotient), 32'd0);
    chk("reset_remainder", 32'(Remainder), 32'd0);
    chk("reset_divbyzero", 32'(DivByZero), 32'd0);
    rst = 1'b0;

    run_op(1'b0, 4'd13, 4'd3, lat);
    chk("13_3_latency", 32'(lat), 32'd5);
    chk("13_3_quotient", 32'(Quotient), 32'd4);
    chk("13_3_remainder", 32'(Remainder), 32'd1);
    chk("13_3_divbyzero", 32'(DivByZero), 32'd0);

    run_op(1'b0, 4'd7, 4'd0, lat);
    chk("7_0_latency", 32'(lat), 32'd1);
    chk("7_0_quotient", 32'(Quotient), 32'd15);
    chk("7_0_remainder", 32'(Remainder), 32'd7);
    chk("7_0_divbyzero", 32'(DivByZero), 32'd1);

    run_op(1'b0, 4'd2, 4'd9, lat);
    chk("2_9_latency", 32'(lat), 32'd5);
    chk("2_9_quotient", 32'(Quotient), 32'd0);
    chk("2_9_remainder", 32'(Remainder), 32'd2);

    run_op(1'b0, 4'd15, 4'd1, lat);
    chk("15_1_quotient", 32'(Quotient), 32'd15);
    chk("15_1_remainder", 32'(Remainder), 32'd0);

    // start pulsed mid-RUN with other operands must be ignored
    @(negedge clk);
    Dividend = 4'd13; Divisor = 4'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0; Dividend = 4'd0; Divisor = 4'd0;
    @(negedge clk);
    Dividend = 4'd9; Divisor = 4'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 3;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat = lat + 1;
    end
    chk("midrun_latency", 32'(lat), 32'd5);
    chk("midrun_quotient", 32'(Quotient), 32'd4);
    chk("midrun_remainder", 32'(Remainder), 32'd1);
    repeat (6) begin
      @(negedge clk);
      chk("midrun_single_done", 32'(done), 32'd0);
    end

    // back-to-back: second start issued in the DONE cycle of the first
    run_op(1'b0, 4'd13, 4'd3, lat);
    run_op(1'b1, 4'd9, 4'd2, lat);
    chk("b2b_latency", 32'(lat), 32'd5);
    chk("b2b_quotient", 32'(Quotient), 32'd4);
    chk("b2b_remainder", 32'(Remainder), 32'd1);

    // reset during the second RUN cycle of 14/5
    @(negedge clk);
    Dividend = 4'd14; Divisor = 4'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_quotient", 32'(Quotient), 32'd0);
    chk("midrst_remainder", 32'(Remainder), 32'd0);
    chk("midrst_divbyzero", 32'(DivByZero), 32'd0);
    repeat (8) begin
      @(negedge clk);
      chk("midrst_no_done", 32'(done), 32'd0);
    end
    run_op(1'b0, 4'd14, 4'd5, lat);
    chk("14_5_quotient", 32'(Quotient), 32'd2);
    chk("14_5_remainder", 32'(Remainder), 32'd4);

    for (int n = 0; n < 16; n++) begin
      for (int d = 1; d < 16; d++) begin
        run_op(1'b0, 4'(n), 4'(d), lat);
        chk("sweep_latency", 32'(lat), 32'd5);
        chk("sweep_identity", 32'(int'(Quotient) * d + int'(Remainder)), 32'(n));
        chk("sweep_rem_lt_div", 32'(int'(Remainder) < d), 32'd1);
      end
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
